dmem_lsu_initiator: RTL and testbench

//  Load/store initiator for the data memory's stall-handshake interface. Accepts one

---
 rtl/dmem_lsu_initiator.sv | 208 ++++++++++++++++++++
 tb/tb_dmem_lsu_initiator.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_initiator.sv
// dmem_lsu_initiator
// Load/store initiator for a data memory that signals busy through mem_clk_stall.
// One MEM-stage request is accepted at a time. It is encoded into a sign/width mask
// and issued as a single-cycle read or write strobe. The initiator then waits for the
// stall to rise and fall again. Finally it returns the load data, or an error, as a
// one-cycle response pulse that the consumer cannot backpressure.
//
// Build option:
//   DMEM_MISALIGN_CHECK_EN - when defined, misaligned halfword/word accesses are
//                            rejected on the error path without touching memory.
//                            When undefined, addresses pass through unchecked.
module dmem_lsu_initiator #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERR} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               seen_q, seen_d;
  logic               we_q, we_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_write_data_q, mem_write_data_d;
  logic               mem_memwrite_q, mem_memwrite_d;
  logic               mem_memread_q, mem_memread_d;
  logic [3:0]         mem_sign_mask_q, mem_sign_mask_d;

  logic               accept;
  logic [3:0]         req_mask;
  logic               req_ok;

  // {sign, width} encoding; an all-zero mask marks an illegal funct3
  function automatic logic [3:0] sign_mask_f(input logic we, input logic [2:0] f3);
    logic [3:0] m;
    m = 4'b0000;
    if (we) begin
      case (f3)
        3'b000:  m = 4'b0001;
        3'b001:  m = 4'b0011;
        3'b010:  m = 4'b0111;
        default: m = 4'b0000;
      endcase
    end else begin
      case (f3)
        3'b000:  m = 4'b1001;
        3'b001:  m = 4'b1011;
        3'b010:  m = 4'b0111;
        3'b100:  m = 4'b0001;
        3'b101:  m = 4'b0011;
        default: m = 4'b0000;
      endcase
    end
    return m;
  endfunction

`ifdef DMEM_MISALIGN_CHECK_EN
  // halfwords need addr[0]==0, words need addr[1:0]==0
  function automatic logic aligned_f(input logic [2:0] width, input logic [1:0] a);
    logic ok;
    ok = 1'b1;
    if (width == 3'b011 && a[0])          ok = 1'b0;
    if (width == 3'b111 && a != 2'b00)    ok = 1'b0;
    return ok;
  endfunction
`endif

  // ready only when idle and the memory is not still finishing an earlier access
  assign req_ready = (state_q == S_IDLE) && !mem_clk_stall;
  assign accept    = req_valid && req_ready;
  assign req_mask  = sign_mask_f(req_we, req_funct3);

  // a request is issued only if legal (and aligned when checking is built in)
  always_comb begin
`ifdef DMEM_MISALIGN_CHECK_EN
    req_ok = (req_mask != 4'b0000) && aligned_f(req_mask[2:0], req_addr[1:0]);
`else
    req_ok = (req_mask != 4'b0000);
`endif
  end

  // next-state and next-output computation for the access sequencer
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    seen_d           = seen_q;
    we_d             = we_q;
    rsp_valid_d      = 1'b0;
    rsp_rdata_d      = rsp_rdata_q;
    rsp_err_d        = rsp_err_q;
    mem_addr_d       = mem_addr_q;
    mem_write_data_d = mem_write_data_q;
    mem_memwrite_d   = 1'b0;
    mem_memread_d    = 1'b0;
    mem_sign_mask_d  = mem_sign_mask_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mem_addr_d       = req_addr;
          mem_write_data_d = req_wdata;
          mem_sign_mask_d  = req_mask;
          we_d             = req_we;
          if (req_ok) begin
            mem_memwrite_d = req_we;
            mem_memread_d  = !req_we;
            state_d        = S_ISSUE;
          end else begin
            state_d        = S_ERR;
          end
        end
      end
      S_ISSUE: begin
        // strobe drops here; the memory samples it on this same edge
        seen_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_clk_stall) seen_d = 1'b1;
        if (seen_q && !mem_clk_stall) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'h0 : mem_read_data;
          rsp_err_d   = 1'b0;
          state_d     = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ERR: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and registered outputs; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      seen_q           <= 1'b0;
      we_q             <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= 32'h0;
      rsp_err_q        <= 1'b0;
      mem_addr_q       <= 32'h0;
      mem_write_data_q <= 32'h0;
      mem_memwrite_q   <= 1'b0;
      mem_memread_q    <= 1'b0;
      mem_sign_mask_q  <= 4'h0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      seen_q           <= seen_d;
      we_q             <= we_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_rdata_q      <= rsp_rdata_d;
      rsp_err_q        <= rsp_err_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_data_q <= mem_write_data_d;
      mem_memwrite_q   <= mem_memwrite_d;
      mem_memread_q    <= mem_memread_d;
      mem_sign_mask_q  <= mem_sign_mask_d;
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_memwrite   = mem_memwrite_q;
  assign mem_memread    = mem_memread_q;
  assign mem_sign_mask  = mem_sign_mask_q;

endmodule

// File: tb/tb_dmem_lsu_initiator.sv
// Directed bench for dmem_lsu_initiator with a small stall-handshake data memory.
module tb_dmem_lsu_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall;

  int n_vec = 0;
  int n_err = 0;

  dmem_lsu_initiator #(.TIMEOUT(15)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_sign_mask  (mem_sign_mask),
    .mem_read_data  (mem_read_data),
    .mem_clk_stall  (mem_clk_stall)
  );

  always #5 clk = ~clk;

  // memory model: samples a strobe when not busy, stall high from that edge for two edges
  bit [7:0]  mem [0:255];
  bit        stall_m = 1'b0;
  bit [1:0]  mcnt = 2'd0;
  bit [31:0] rd_m = 32'h0;
  bit        no_stall = 1'b0;

  assign mem_read_data = rd_m;
  assign mem_clk_stall = stall_m;

  function automatic bit [31:0] mrd(input bit [7:0] a, input bit [3:0] m);
    bit [31:0] r;
    bit [7:0]  b;
    bit [15:0] h;
    r = 32'h0;
    case (m[2:0])
      3'b001: begin b = mem[a]; r = m[3] ? {{24{b[7]}}, b} : {24'h0, b}; end
      3'b011: begin
        h = {mem[{a[7:1], 1'b1}], mem[{a[7:1], 1'b0}]};
        r = m[3] ? {{16{h[15]}}, h} : {16'h0, h};
      end
      default: r = {mem[{a[7:2], 2'b11}], mem[{a[7:2], 2'b10}],
                    mem[{a[7:2], 2'b01}], mem[{a[7:2], 2'b00}]};
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (stall_m) begin
      if (mcnt == 2'd1) stall_m <= 1'b0;
      else mcnt <= mcnt + 2'd1;
    end else if ((mem_memread || mem_memwrite) && !no_stall) begin
      stall_m <= 1'b1;
      mcnt    <= 2'd0;
      if (mem_memwrite) begin
        case (mem_sign_mask[2:0])
          3'b001: mem[mem_addr[7:0]] <= mem_write_data[7:0];
          3'b011: begin
            mem[{mem_addr[7:1], 1'b0}] <= mem_write_data[7:0];
            mem[{mem_addr[7:1], 1'b1}] <= mem_write_data[15:8];
          end
          default: begin
            mem[{mem_addr[7:2], 2'b00}] <= mem_write_data[7:0];
            mem[{mem_addr[7:2], 2'b01}] <= mem_write_data[15:8];
            mem[{mem_addr[7:2], 2'b10}] <= mem_write_data[23:16];
            mem[{mem_addr[7:2], 2'b11}] <= mem_write_data[31:24];
          end
        endcase
      end else begin
        rd_m <= mrd(mem_addr[7:0], mem_sign_mask);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one request; lat counts edges from accept to the response (-1 if none)
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, output int lat, output int rds, output int wrs,
                     output logic [31:0] rdata, output logic err, output logic [3:0] mask);
    int b;
    lat = -1; rds = 0; wrs = 0; rdata = 32'hFFFF_FFFF; err = 1'b0; mask = 4'h0;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    b = 0;
    while (!req_ready && b < 20) begin tick(); b++; end
    if (!req_ready) begin req_valid = 1'b0; return; end
    tick();
    req_valid = 1'b0;
    mask = mem_sign_mask;
    for (int k = 0; k < 40; k++) begin
      rds += int'(mem_memread);
      wrs += int'(mem_memwrite);
      if (rsp_valid) begin
        lat = k; rdata = rsp_rdata; err = rsp_err;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int lat, rds, wrs;
    logic [31:0] rd;
    logic er;
    logic [3:0] mk;

    // reset values
    tick(); tick();
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_strobes", {30'h0, mem_memread, mem_memwrite}, 32'h0);
    chk("rst_mask", {28'h0, mem_sign_mask}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: SW 0x40
    txn(1'b1, 3'b010, 32'h40, 32'hDEADBEEF, lat, rds, wrs, rd, er, mk);
    chk("sw_mask", {28'h0, mk}, 32'h7);
    chk("sw_wr_strobes", wrs, 32'd1);
    chk("sw_rd_strobes", rds, 32'd0);
    chk("sw_latency", lat, 32'd4);
    chk("sw_err", {31'h0, er}, 32'h0);
    chk("sw_rdata", rd, 32'h0);
    chk("sw_addr_held", mem_addr, 32'h40);
    chk("sw_wdata_held", mem_write_data, 32'hDEADBEEF);
    tick();
    chk("sw_rsp_pulse", {31'h0, rsp_valid}, 32'h0);

    // 2: loads of each width
    txn(1'b0, 3'b010, 32'h40, 32'h0, lat, rds, wrs, rd, er, mk);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_rd_strobes", rds, 32'd1);
    chk("lw_wr_strobes", wrs, 32'd0);
    chk("lw_latency", lat, 32'd4);
    txn(1'b0, 3'b000, 32'h43, 32'h0, lat, rds, wrs, rd, er, mk);
    chk("lb_mask", {28'h0, mk}, 32'h9);
    chk("lb_rdata", rd, 32'hFFFFFFDE);
    txn(1'b0, 3'b100, 32'h43, 32'h0, lat, rds, wrs, rd, er, mk);
    chk("lbu_mask", {28'h0, mk}, 32'h1);
    chk("lbu_rdata", rd, 32'h000000DE);
    txn(1'b0, 3'b001, 32'h42, 32'h0, lat, rds, wrs, rd, er, mk);
    chk("lh_mask", {28'h0, mk}, 32'hB);
    chk("lh_rdata", rd, 32'hFFFFDEAD);
    txn(1'b0, 3'b101, 32'h42, 32'h0, lat, rds, wrs, rd, er, mk);
    chk("lhu_mask", {28'h0, mk}, 32'h3);
    chk("lhu_rdata", rd, 32'h0000DEAD);

    // 3: byte/half stores merged into the word
    txn(1'b1, 3'b000, 32'h41, 32'h55, lat, rds, wrs, rd, er, mk);
    chk("sb_mask", {28'h0, mk}, 32'h1);
    txn(1'b0, 3'b010, 32'h40, 32'h0, lat, rds, wrs, rd, er, mk);
    chk("sb_lw_rdata", rd, 32'hDEAD55EF);
    txn(1'b1, 3'b001, 32'h42, 32'h1234, lat, rds, wrs, rd, er, mk);
    chk("sh_mask", {28'h0, mk}, 32'h3);
    txn(1'b0, 3'b010, 32'h40, 32'h0, lat, rds, wrs, rd, er, mk);
    chk("sh_lw_rdata", rd, 32'h123455EF);

    // 4: illegal funct3 and alignment
    txn(1'b0, 3'b011, 32'h40, 32'h0, lat, rds, wrs, rd, er, mk);
    chk("ill_ld_latency", lat, 32'd1);
    chk("ill_ld_err", {31'h0, er}, 32'h1);
    chk("ill_ld_strobes", rds + wrs, 32'd0);
    chk("ill_ld_rdata", rd, 32'h0);
    txn(1'b1, 3'b101, 32'h40, 32'h0, lat, rds, wrs, rd, er, mk);
    chk("ill_st_latency", lat, 32'd1);
    chk("ill_st_err", {31'h0, er}, 32'h1);
    chk("ill_st_strobes", rds + wrs, 32'd0);
    txn(1'b0, 3'b010, 32'h42, 32'h0, lat, rds, wrs, rd, er, mk);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("mis_lw_latency", lat, 32'd1);
    chk("mis_lw_err", {31'h0, er}, 32'h1);
    chk("mis_lw_strobes", rds + wrs, 32'd0);
`else
    chk("mis_lw_latency", lat, 32'd4);
    chk("mis_lw_err", {31'h0, er}, 32'h0);
    chk("mis_lw_strobes", rds, 32'd1);
`endif

    // 5: memory never stalls -> timeout
    no_stall = 1'b1;
    txn(1'b0, 3'b010, 32'h40, 32'h0, lat, rds, wrs, rd, er, mk);
    chk("to_latency", lat, 32'd16);
    chk("to_err", {31'h0, er}, 32'h1);
    chk("to_rdata", rd, 32'h0);
    chk("to_strobes", rds, 32'd1);
    no_stall = 1'b0;
    tick();

    // 6: reset mid-access while memory is stalled
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80; req_valid = 1'b1;
    tick();                       // edge A
    req_valid = 1'b0;
    tick();                       // A+1
    chk("busy_ready", {31'h0, req_ready}, 32'h0);
    tick();                       // A+2
    rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_mask", {28'h0, mem_sign_mask}, 32'h0);
    chk("mid_rst_strobes", {30'h0, mem_memread, mem_memwrite}, 32'h0);
    chk("mid_rst_ready", {31'h0, req_ready}, 32'h0);
    #2;
    rst_n = 1'b1;
    tick();                       // A+3: stall falls
    chk("post_rst_ready", {31'h0, req_ready}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
